// File: rtl/knap_search.sv
// knap_search: sequential exhaustive knapsack solver.
//
// Enumerates every selection mask over N_ITEMS loadable items, in ascending mask order.
// For each mask it spends N_ITEMS cycles accumulating value/weight/volume (one item per
// cycle) and one cycle checking feasibility. It reports the highest-value feasible mask.
// On a tie in value, the lowest mask wins.
//
// Build option: define KNAP_VOLUME_EN to build the volume table, the volume accumulator
// and the volume term of the feasibility test. Without it, item_volume_i and max_volume_i
// are ignored, and the volume term always passes.
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset; also clears the item table
//   item_we_i          item table write strobe (honoured only in idle/done)
//   item_addr_i        item index; writes at or beyond N_ITEMS are dropped
//   item_value_i       item value
//   item_weight_i      item weight
//   item_volume_i      item volume
//   min_value_i        minimum total value (latched on start)
//   max_weight_i       weight capacity (latched on start)
//   max_volume_i       volume capacity (latched on start)
//   start_i            start a search (ignored while busy)
//   busy_o             search in progress, through the done cycle inclusive
//   done_o             one-cycle completion pulse
//   found_o            at least one feasible mask exists
//   best_mask_o        winning selection, bit i = item i
//   best_value_o       value of best_mask_o
//   feasible_count_o   number of feasible masks
module knap_search #(
  parameter int unsigned N_ITEMS = 5,
  parameter int unsigned W       = 16,
  parameter int unsigned ACC_W   = W + $clog2(N_ITEMS + 1)
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           item_we_i,
  input  logic [((N_ITEMS > 1) ? $clog2(N_ITEMS) : 1)-1:0] item_addr_i,
  input  logic [W-1:0]                                   item_value_i,
  input  logic [W-1:0]                                   item_weight_i,
  input  logic [W-1:0]                                   item_volume_i,
  input  logic [ACC_W-1:0]                               min_value_i,
  input  logic [ACC_W-1:0]                               max_weight_i,
  input  logic [ACC_W-1:0]                               max_volume_i,
  input  logic                                           start_i,
  output logic                                           busy_o,
  output logic                                           done_o,
  output logic                                           found_o,
  output logic [N_ITEMS-1:0]                             best_mask_o,
  output logic [ACC_W-1:0]                               best_value_o,
  output logic [N_ITEMS:0]                               feasible_count_o
);

  localparam int unsigned AddrW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned CntW  = N_ITEMS + 1;
  localparam logic [AddrW-1:0] LastIdx = AddrW'(N_ITEMS - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StCheck, StDone} state_e;

  state_e state_q;

  // Item table
  logic [W-1:0] val_q [N_ITEMS];
  logic [W-1:0] wgt_q [N_ITEMS];

  // Search state
  logic [N_ITEMS-1:0] mask_q;
  logic [AddrW-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_val_q, acc_val_d;
  logic [ACC_W-1:0]   acc_wgt_q, acc_wgt_d;
  logic [ACC_W-1:0]   min_val_q;
  logic [ACC_W-1:0]   max_wgt_q;

  // Registered outputs
  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic [N_ITEMS-1:0] best_mask_q;
  logic [ACC_W-1:0]   best_val_q;
  logic [CntW-1:0]    cnt_q;

  logic wr_ok;
  logic sel;
  logic vol_ok;
  logic feasible;
  logic better;

`ifdef KNAP_VOLUME_EN
  logic [W-1:0]     vol_q [N_ITEMS];
  logic [ACC_W-1:0] acc_vol_q, acc_vol_d;
  logic [ACC_W-1:0] max_vol_q;
`else
  logic unused_volume;
  assign unused_volume = ^{item_volume_i, max_volume_i};
`endif

  always_comb begin
    // The table is frozen for the whole search so every mask sees the same items.
    wr_ok = item_we_i && ((state_q == StIdle) || (state_q == StDone)) &&
            ({1'b0, item_addr_i} < (AddrW + 1)'(N_ITEMS));

    sel       = mask_q[idx_q];
    acc_val_d = acc_val_q + (sel ? ACC_W'(val_q[idx_q]) : '0);
    acc_wgt_d = acc_wgt_q + (sel ? ACC_W'(wgt_q[idx_q]) : '0);
`ifdef KNAP_VOLUME_EN
    acc_vol_d = acc_vol_q + (sel ? ACC_W'(vol_q[idx_q]) : '0);
    vol_ok    = (acc_vol_q <= max_vol_q);
`else
    vol_ok    = 1'b1;
`endif

    feasible = (acc_val_q >= min_val_q) && (acc_wgt_q <= max_wgt_q) && vol_ok;
    // Strict compare: masks are visited in ascending order, so ties keep the lowest mask.
    better   = !found_q || (acc_val_q > best_val_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      idx_q       <= '0;
      acc_val_q   <= '0;
      acc_wgt_q   <= '0;
      min_val_q   <= '0;
      max_wgt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      best_mask_q <= '0;
      best_val_q  <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(N_ITEMS); i++) begin
        val_q[i] <= '0;
        wgt_q[i] <= '0;
      end
`ifdef KNAP_VOLUME_EN
      acc_vol_q <= '0;
      max_vol_q <= '0;
      for (int i = 0; i < int'(N_ITEMS); i++) begin
        vol_q[i] <= '0;
      end
`endif
    end else begin
      if (wr_ok) begin
        val_q[item_addr_i] <= item_value_i;
        wgt_q[item_addr_i] <= item_weight_i;
`ifdef KNAP_VOLUME_EN
        vol_q[item_addr_i] <= item_volume_i;
`endif
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            min_val_q   <= min_value_i;
            max_wgt_q   <= max_weight_i;
            mask_q      <= '0;
            idx_q       <= '0;
            acc_val_q   <= '0;
            acc_wgt_q   <= '0;
            found_q     <= 1'b0;
            best_mask_q <= '0;
            best_val_q  <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= StAccum;
`ifdef KNAP_VOLUME_EN
            max_vol_q   <= max_volume_i;
            acc_vol_q   <= '0;
`endif
          end
        end

        StAccum: begin
          acc_val_q <= acc_val_d;
          acc_wgt_q <= acc_wgt_d;
`ifdef KNAP_VOLUME_EN
          acc_vol_q <= acc_vol_d;
`endif
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            state_q <= StCheck;
          end else begin
            idx_q <= idx_q + AddrW'(1);
          end
        end

        StCheck: begin
          if (feasible) begin
            cnt_q <= cnt_q + CntW'(1);
            if (better) begin
              found_q     <= 1'b1;
              best_mask_q <= mask_q;
              best_val_q  <= acc_val_q;
            end
          end
          acc_val_q <= '0;
          acc_wgt_q <= '0;
`ifdef KNAP_VOLUME_EN
          acc_vol_q <= '0;
`endif
          idx_q <= '0;
          if (&mask_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            mask_q  <= mask_q + N_ITEMS'(1);
            state_q <= StAccum;
          end
        end

        StDone: begin
          // A start seen here is dropped; it is honoured once back in idle.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign found_o          = found_q;
  assign best_mask_o      = best_mask_q;
  assign best_value_o     = best_val_q;
  assign feasible_count_o = cnt_q;

endmodule

// File: tb/tb_knap_search.sv
// Testbench for knap_search: table-driven scenarios, hand-written multi-cycle sequences
// (reset mid-search, busy write guard, start during done) and randomized tables checked
// against a brute-force enumeration model.
module tb_knap_search;

  localparam int unsigned N       = 5;
  localparam int unsigned W       = 16;
  localparam int unsigned AccW    = W + $clog2(N + 1);
  localparam int unsigned AW      = $clog2(N);
  localparam int          DoneCyc = 1 + (1 << N) * (N + 1);

  localparam logic [N-1:0][W-1:0] CV = {16'd10, 16'd1, 16'd2, 16'd2, 16'd4};
  localparam logic [N-1:0][W-1:0] CW = {16'd4, 16'd1, 16'd2, 16'd1, 16'd12};
  localparam logic [N-1:0][W-1:0] CO = {16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
  localparam logic [N-1:0][W-1:0] TV = {16'd0, 16'd0, 16'd0, 16'd5, 16'd5};
  localparam logic [N-1:0][W-1:0] Z  = '0;

  logic            clk = 1'b0;
  logic            rst;
  logic            item_we;
  logic [AW-1:0]   item_addr;
  logic [W-1:0]    item_value, item_weight, item_volume;
  logic [AccW-1:0] min_value, max_weight, max_volume;
  logic            start;
  logic            busy, done, found;
  logic [N-1:0]    best_mask;
  logic [AccW-1:0] best_value;
  logic [N:0]      feasible_count;

  always #5 clk = ~clk;

  knap_search #(.N_ITEMS(N), .W(W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .item_we_i       (item_we),
    .item_addr_i     (item_addr),
    .item_value_i    (item_value),
    .item_weight_i   (item_weight),
    .item_volume_i   (item_volume),
    .min_value_i     (min_value),
    .max_weight_i    (max_weight),
    .max_volume_i    (max_volume),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .found_o         (found),
    .best_mask_o     (best_mask),
    .best_value_o    (best_value),
    .feasible_count_o(feasible_count)
  );

  typedef struct {
    string                 name;
    logic [N-1:0][W-1:0]   v, w, o;
    logic [AccW-1:0]       mn, mw, mv;
    logic                  ef;
    logic [N-1:0]          em;
    logic [AccW-1:0]       ebv;
    int                    ecnt;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;

  // Bench copy of what the item table should hold.
  logic [W-1:0] tv[N], tw[N], tvo[N];

  function automatic vec_t mk(input string nm, input logic [N-1:0][W-1:0] v, w, o,
                              input int mn, mw, mv, input logic ef, input logic [N-1:0] em,
                              input int ebv, input int ecnt);
    vec_t r;
    r.name = nm; r.v = v; r.w = w; r.o = o;
    r.mn = AccW'(mn); r.mw = AccW'(mw); r.mv = AccW'(mv);
    r.ef = ef; r.em = em; r.ebv = AccW'(ebv); r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All driving tasks are entered and left at a falling edge.
  task automatic write_item(input int a, input int v, input int w, input int o);
    item_we     = 1'b1;
    item_addr   = AW'(a);
    item_value  = W'(v);
    item_weight = W'(w);
    item_volume = W'(o);
    @(negedge clk);
    item_we = 1'b0;
  endtask

  task automatic load_table(input logic [N-1:0][W-1:0] v, w, o);
    for (int i = 0; i < int'(N); i++) begin
      write_item(i, int'(v[i]), int'(w[i]), int'(o[i]));
      tv[i] = v[i]; tw[i] = w[i]; tvo[i] = o[i];
    end
  endtask

  task automatic kick(input logic [AccW-1:0] mn, mw, mv);
    min_value  = mn;
    max_weight = mw;
    max_volume = mv;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_cycle1", busy, 1);
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 4 * DoneCyc) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Brute force over every subset, straight from the selection rules.
  task automatic model(input logic [AccW-1:0] mn, mw, mv, output logic f,
                       output logic [N-1:0] bm, output logic [AccW-1:0] bv, output int cnt);
    longint best;
    best = -1; bm = '0; cnt = 0;
    for (int m = 0; m < (1 << N); m++) begin
      longint sv, sw, so;
      bit ok;
      sv = 0; sw = 0; so = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (((m >> i) & 1) == 1) begin
          sv += longint'(tv[i]);
          sw += longint'(tw[i]);
          so += longint'(tvo[i]);
        end
      end
      ok = (sv >= longint'(mn)) && (sw <= longint'(mw));
`ifdef KNAP_VOLUME_EN
      ok = ok && (so <= longint'(mv));
`endif
      if (ok) begin
        cnt++;
        if (sv > best) begin
          best = sv;
          bm   = N'(m);
        end
      end
    end
    f  = (best >= 0);
    bv = f ? AccW'(best) : '0;
  endtask

  task automatic finish_run(input string name, input int k, input logic ef,
                            input logic [N-1:0] em, input logic [AccW-1:0] ebv, input int ecnt);
    check({name, "_done_seen"}, done, 1);
    check({name, "_done_cycle"}, k, DoneCyc);
    check({name, "_found"}, found, ef);
    check({name, "_mask"}, best_mask, em);
    check({name, "_value"}, best_value, ebv);
    check({name, "_count"}, feasible_count, ecnt);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
    check({name, "_busy_clear"}, busy, 0);
    check({name, "_value_hold"}, best_value, ebv);
  endtask

  task automatic run_check(input string name, input logic [AccW-1:0] mn, mw, mv,
                           input logic ef, input logic [N-1:0] em,
                           input logic [AccW-1:0] ebv, input int ecnt);
    int k;
    kick(mn, mw, mv);
    wait_done(1, k);
    finish_run(name, k, ef, em, ebv, ecnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic        mf;
    logic [N-1:0] mm;
    logic [AccW-1:0] mbv, rmn, rmw, rmv;
    int          mc;
    logic [N-1:0][W-1:0] rv, rw, ro;

    rst = 1'b1; item_we = 1'b0; item_addr = '0;
    item_value = '0; item_weight = '0; item_volume = '0;
    min_value = '0; max_weight = '0; max_volume = '0; start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      tv[i] = '0; tw[i] = '0; tvo[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_mask", best_mask, 0);
    check("rst_value", best_value, 0);
    check("rst_count", feasible_count, 0);

    vecs[0] = mk("common", CV, CW, CO, 15, 16, 10, 1'b1, 5'b11110, 15, 1);
    vecs[1] = mk("min16", CV, CW, CO, 16, 16, 10, 1'b0, 5'b00000, 0, 0);
    vecs[2] = mk("tie", TV, TV, Z, 0, 5, 0, 1'b1, 5'b00001, 5, 24);
`ifdef KNAP_VOLUME_EN
    vecs[3] = mk("vol3", CV, CW, CO, 15, 16, 3, 1'b0, 5'b00000, 0, 0);
`else
    vecs[3] = mk("vol3", CV, CW, CO, 15, 16, 3, 1'b1, 5'b11110, 15, 1);
`endif

    for (int i = 0; i < 4; i++) begin
      load_table(vecs[i].v, vecs[i].w, vecs[i].o);
      run_check(vecs[i].name, vecs[i].mn, vecs[i].mw, vecs[i].mv,
                vecs[i].ef, vecs[i].em, vecs[i].ebv, vecs[i].ecnt);
    end

    // Reset at cycle 50 of a search, then confirm the table came back empty.
    load_table(CV, CW, CO);
    kick(15, 16, 10);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_found", found, 0);
    check("midrst_mask", best_mask, 0);
    check("midrst_value", best_value, 0);
    check("midrst_count", feasible_count, 0);
    for (int i = 0; i < int'(N); i++) begin
      tv[i] = '0; tw[i] = '0; tvo[i] = '0;
    end
    model(0, 0, 0, mf, mm, mbv, mc);
    run_check("cleared_table", 0, 0, 0, mf, mm, mbv, mc);
    load_table(CV, CW, CO);
    run_check("after_reset", 15, 16, 10, 1'b1, 5'b11110, 15, 1);

    // Writes and start pulses while busy are dropped; limit inputs move freely.
    kick(15, 16, 10);
    repeat (19) @(negedge clk);
    write_item(4, 0, 0, 0);
    start     = 1'b1;
    min_value = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done(22, k);
    finish_run("guard", k, 1'b1, 5'b11110, 15, 1);
    run_check("guard_table_kept", 15, 16, 10, 1'b1, 5'b11110, 15, 1);

    // Start held through the done cycle is taken only in the following idle cycle.
    kick(15, 16, 10);
    wait_done(1, k);
    check("held_done_seen", done, 1);
    min_value = AccW'(16);
    start     = 1'b1;
    @(negedge clk);
    check("held_start_in_done_ignored", busy, 0);
    check("held_results_kept", best_value, 15);
    @(negedge clk);
    start = 1'b0;
    check("held_start_accepted", busy, 1);
    wait_done(1, k);
    finish_run("held_restart", k, 1'b0, 5'b00000, 0, 0);

    // Randomized tables and limits against the enumeration model.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        rv[i] = W'($urandom_range(0, 15));
        rw[i] = W'($urandom_range(0, 15));
        ro[i] = W'($urandom_range(0, 7));
      end
      load_table(rv, rw, ro);
      write_item(int'(N) + (r % 3), 16'hffff, 0, 0);
      rmn = AccW'($urandom_range(0, 30));
      rmw = AccW'($urandom_range(0, 40));
      rmv = AccW'($urandom_range(0, 20));
      model(rmn, rmw, rmv, mf, mm, mbv, mc);
      run_check($sformatf("rand%0d", r), rmn, rmw, rmv, mf, mm, mbv, mc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
